muldiv_seq: RTL

- Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU issued from the Execute stage and runs a 32-iteration shift-add or restoring-divide engine.
- Writes HI/LO on completion.
- Generates the pipeline stall request whenever a later instruction needs HI/LO or the engine while the engine is busy.

---
 rtl/muldiv_seq_if.sv | 30 +++
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Bundle between the Execute/Decode stages and the multiply/divide sequencer.
// The core drives the master side; the sequencer owns HI/LO on the slave side.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hlreadD;
  logic             hlwriteE;
  logic             hlselE;
  logic [WIDTH-1:0] hlwdataE;
  logic             abort;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, opE, srcaE, srcbE, hlreadD, hlwriteE, hlselE, hlwdataE, abort,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, hlreadD, hlwriteE, hlselE, hlwdataE, abort,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO: one shift-add or restoring
// step per cycle, a final sign-fix cycle, and a stall request while busy.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave mdBus
);
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0]    LAST_CNT = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0]    CNT_ONE  = CNTW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             nextState_s;
  logic [CNTW-1:0]    count_r;
  logic [2*WIDTH-1:0] acc_r;      // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opB_r;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rawA_r;
  logic               isDiv_r;
  logic               resNeg_r;
  logic               remNeg_r;
  logic               divZero_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               signedOp_s;
  logic               aNeg_s;
  logic               bNeg_s;
  logic [WIDTH-1:0]   absA_s;
  logic [WIDTH-1:0]   absB_s;
  logic [WIDTH:0]     mulSum_s;
  logic [2*WIDTH-1:0] mulNext_s;
  logic [WIDTH:0]     divShift_s;
  logic [WIDTH:0]     divTrial_s;
  logic [2*WIDTH-1:0] divNext_s;
  logic [2*WIDTH-1:0] prodFix_s;
  logic [WIDTH-1:0]   fixHi_s;
  logic [WIDTH-1:0]   fixLo_s;

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
    negW = ~x + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] x);
    neg2W = ~x + ONE_2W;
  endfunction

  assign signedOp_s = ~mdBus.opE[0];
  assign aNeg_s     = signedOp_s & mdBus.srcaE[WIDTH-1];
  assign bNeg_s     = signedOp_s & mdBus.srcbE[WIDTH-1];
  assign absA_s     = aNeg_s ? negW(mdBus.srcaE) : mdBus.srcaE;
  assign absB_s     = bNeg_s ? negW(mdBus.srcbE) : mdBus.srcbE;

  // One shift-add step: add the multiplicand into the upper half when the multiplier LSB is set.
  assign mulSum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opB_r};
  assign mulNext_s = acc_r[0] ? {mulSum_s, acc_r[WIDTH-1:1]}
                              : {1'b0, acc_r[2*WIDTH-1:1]};

  // One restoring step: shift in the next dividend bit and keep the difference only if non-negative.
  assign divShift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign divTrial_s = divShift_s - {1'b0, opB_r};
  assign divNext_s  = divTrial_s[WIDTH] ? {divShift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                        : {divTrial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

  // Sign correction of the finished result, evaluated during FIX.
  always_comb begin
    prodFix_s = acc_r;
    fixHi_s   = '0;
    fixLo_s   = '0;
    if (!isDiv_r) begin
      if (resNeg_r) begin
        prodFix_s = neg2W(acc_r);
      end else begin
        prodFix_s = acc_r;
      end
      fixHi_s = prodFix_s[2*WIDTH-1:WIDTH];
      fixLo_s = prodFix_s[WIDTH-1:0];
    end else if (divZero_r) begin
      fixHi_s = rawA_r;
      fixLo_s = '1;
    end else begin
      fixLo_s = resNeg_r ? negW(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      fixHi_s = remNeg_r ? negW(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (mdBus.startE) begin
          nextState_s = mdBus.opE[1] ? DIV : MUL;
        end else begin
          nextState_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (mdBus.abort) begin
          nextState_s = IDLE;
        end else if (count_r == LAST_CNT) begin
          nextState_s = FIX;
        end else begin
          nextState_s = state_r;
        end
      end
      FIX:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register with busy/done status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE);
      done_r  <= (state_r == FIX) && !mdBus.abort;
    end
  end

  // Operand capture, iteration datapath and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= '0;
      acc_r     <= '0;
      opB_r     <= '0;
      rawA_r    <= '0;
      isDiv_r   <= 1'b0;
      resNeg_r  <= 1'b0;
      remNeg_r  <= 1'b0;
      divZero_r <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mdBus.startE) begin
            count_r   <= '0;
            acc_r     <= {{WIDTH{1'b0}}, (mdBus.opE[1] ? absA_s : absB_s)};
            opB_r     <= mdBus.opE[1] ? absB_s : absA_s;
            rawA_r    <= mdBus.srcaE;
            isDiv_r   <= mdBus.opE[1];
            resNeg_r  <= aNeg_s ^ bNeg_s;
            remNeg_r  <= aNeg_s;
            divZero_r <= (mdBus.srcbE == {WIDTH{1'b0}});
          end else if (mdBus.hlwriteE) begin
            if (mdBus.hlselE) begin
              hi_r <= mdBus.hlwdataE;
            end else begin
              lo_r <= mdBus.hlwdataE;
            end
          end
        end
        MUL: begin
          acc_r   <= mulNext_s;
          count_r <= count_r + CNT_ONE;
        end
        DIV: begin
          acc_r   <= divNext_s;
          count_r <= count_r + CNT_ONE;
        end
        FIX: begin
          if (!mdBus.abort) begin
            hi_r <= fixHi_s;
            lo_r <= fixLo_s;
          end
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  assign mdBus.busy  = busy_r;
  assign mdBus.done  = done_r;
  assign mdBus.hi    = hi_r;
  assign mdBus.lo    = lo_r;
  assign mdBus.stall = busy_r & (mdBus.startE | mdBus.hlreadD | mdBus.hlwriteE);

endmodule
